// File: rtl/instr_decode_stage.sv
// MIPS-style decode stage with a registered output bundle and a per-register FP
// result scoreboard. Any FP instruction that would race a pending result is stalled.
module instr_decode_stage #(
    parameter int FP_LAT   = 4,
    parameter int IMM_SEXT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [31:0] instruction,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        branch,
    output logic        reg_write,
    output logic        mem_write,
    output logic        alu_src,
    output logic        jal,
    output logic        fp_reg_write,
    output logic        fp_alu_src,
    output logic        fp_reg_dst,
    output logic [1:0]  jump,
    output logic [1:0]  reg_dst,
    output logic [1:0]  mem_to_reg,
    output logic [2:0]  alu_ctrl,
    output logic [2:0]  fp_alu_ctrl,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [31:0] imm,
    output logic [25:0] target,
    output logic        illegal,
    output logic [15:0] stall_count
);

    localparam logic [3:0] LAT = 4'(FP_LAT);

    logic [5:0]  f_op;
    logic [5:0]  f_func;
    logic [4:0]  f_rs;
    logic [4:0]  f_rt;
    logic [4:0]  f_rd;
    logic [31:0] f_imm;

    logic       d_branch, d_reg_write, d_mem_write, d_alu_src, d_jal;
    logic       d_fp_reg_write, d_fp_alu_src, d_fp_reg_dst, d_illegal;
    logic [1:0] d_jump, d_reg_dst, d_mem_to_reg;
    logic [2:0] d_alu_ctrl, d_fp_alu_ctrl;

    logic [3:0] sb [32];
    logic [4:0] fp_dest;
    logic       is_fp_op;
    logic       hazard;
    logic       accept;

    assign f_op   = instruction[31:26];
    assign f_rs   = instruction[25:21];
    assign f_rt   = instruction[20:16];
    assign f_rd   = instruction[15:11];
    assign f_func = instruction[5:0];

    always_comb begin
        d_branch       = 1'b0;
        d_reg_write    = 1'b0;
        d_mem_write    = 1'b0;
        d_alu_src      = 1'b0;
        d_jal          = 1'b0;
        d_fp_reg_write = 1'b0;
        d_fp_alu_src   = 1'b0;
        d_fp_reg_dst   = 1'b0;
        d_illegal      = 1'b0;
        d_jump         = 2'd0;
        d_reg_dst      = 2'd0;
        d_mem_to_reg   = 2'd0;
        d_alu_ctrl     = 3'd0;
        d_fp_alu_ctrl  = 3'd0;
        case (f_op)
            6'h23: begin
                d_reg_write  = 1'b1;
                d_alu_src    = 1'b1;
                d_mem_to_reg = 2'd1;
            end
            6'h2B: begin
                d_mem_write = 1'b1;
                d_alu_src   = 1'b1;
            end
            6'h02: d_jump = 2'd2;
            6'h03: begin
                d_reg_write  = 1'b1;
                d_jal        = 1'b1;
                d_jump       = 2'd2;
                d_reg_dst    = 2'd2;
                d_mem_to_reg = 2'd2;
            end
            6'h05: begin
                d_branch   = 1'b1;
                d_alu_ctrl = 3'd1;
            end
            6'h08: begin
                d_reg_write = 1'b1;
                d_alu_src   = 1'b1;
            end
            6'h00: begin
                d_reg_dst = 2'd1;
                case (f_func)
                    6'h20: d_reg_write = 1'b1;
                    6'h22: begin
                        d_reg_write = 1'b1;
                        d_alu_ctrl  = 3'd1;
                    end
                    6'h0E: begin
                        d_reg_write = 1'b1;
                        d_alu_src   = 1'b1;
                        d_alu_ctrl  = 3'd2;
                    end
                    6'h2A: begin
                        d_reg_write = 1'b1;
                        d_alu_ctrl  = 3'd3;
                    end
                    6'h08: begin
                        d_jump    = 2'd1;
                        d_reg_dst = 2'd0;
                    end
                    default: begin
                        d_reg_dst = 2'd0;
                        d_illegal = 1'b1;
                    end
                endcase
            end
            6'h11: begin
                d_fp_reg_write = 1'b1;
                d_fp_reg_dst   = 1'b1;
                case (f_func)
                    6'h00: d_fp_alu_ctrl = 3'd0;
                    6'h02: d_fp_alu_ctrl = 3'd1;
                    6'h03: d_fp_alu_ctrl = 3'd2;
                    6'h04: d_fp_alu_ctrl = 3'd3;
                    default: begin
                        d_fp_reg_write = 1'b0;
                        d_fp_reg_dst   = 1'b0;
                        d_illegal      = 1'b1;
                    end
                endcase
            end
            6'h12: begin
                d_fp_reg_write = 1'b1;
                d_fp_alu_src   = 1'b1;
                d_fp_alu_ctrl  = 3'd1;
            end
            default: d_illegal = 1'b1;
        endcase
    end

    // JAL carries the link offset in imm instead of its (nonexistent) immediate field.
    always_comb begin
        if (IMM_SEXT != 0) f_imm = {{16{instruction[15]}}, instruction[15:0]};
        else               f_imm = {16'd0, instruction[15:0]};
        if (f_op == 6'h03) f_imm = 32'd8;
    end

    assign is_fp_op = (f_op == 6'h11) || (f_op == 6'h12);
    assign fp_dest  = d_fp_reg_dst ? f_rd : f_rt;
    assign hazard   = is_fp_op && ((sb[f_rs] != 4'd0) ||
                                   ((f_op == 6'h11) && (sb[f_rt] != 4'd0)) ||
                                   (sb[fp_dest] != 4'd0));
    assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) sb[i] <= 4'd0;
        end else begin
            for (int i = 0; i < 32; i++) begin
                if (accept && d_fp_reg_write && (fp_dest == 5'(i))) sb[i] <= LAT;
                else if (sb[i] != 4'd0)                              sb[i] <= sb[i] - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= 16'd0;
        end else if (in_valid && hazard && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            branch       <= 1'b0;
            reg_write    <= 1'b0;
            mem_write    <= 1'b0;
            alu_src      <= 1'b0;
            jal          <= 1'b0;
            fp_reg_write <= 1'b0;
            fp_alu_src   <= 1'b0;
            fp_reg_dst   <= 1'b0;
            illegal      <= 1'b0;
            jump         <= 2'd0;
            reg_dst      <= 2'd0;
            mem_to_reg   <= 2'd0;
            alu_ctrl     <= 3'd0;
            fp_alu_ctrl  <= 3'd0;
            rs           <= 5'd0;
            rt           <= 5'd0;
            rd           <= 5'd0;
            imm          <= 32'd0;
            target       <= 26'd0;
        end else if (accept) begin
            out_valid    <= 1'b1;
            branch       <= d_branch;
            reg_write    <= d_reg_write;
            mem_write    <= d_mem_write;
            alu_src      <= d_alu_src;
            jal          <= d_jal;
            fp_reg_write <= d_fp_reg_write;
            fp_alu_src   <= d_fp_alu_src;
            fp_reg_dst   <= d_fp_reg_dst;
            illegal      <= d_illegal;
            jump         <= d_jump;
            reg_dst      <= d_reg_dst;
            mem_to_reg   <= d_mem_to_reg;
            alu_ctrl     <= d_alu_ctrl;
            fp_alu_ctrl  <= d_fp_alu_ctrl;
            rs           <= f_rs;
            rt           <= f_rt;
            rd           <= f_rd;
            imm          <= f_imm;
            target       <= instruction[25:0];
        end else if (out_ready || flush) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed bench for instr_decode_stage: decode table, latency, FP scoreboard
// stalls, backpressure, flush and asynchronous reset.
module tb_instr_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] instruction;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic        branch, reg_write, mem_write, alu_src, jal;
    logic        fp_reg_write, fp_alu_src, fp_reg_dst;
    logic [1:0]  jump, reg_dst, mem_to_reg;
    logic [2:0]  alu_ctrl, fp_alu_ctrl;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm;
    logic [25:0] target;
    logic        illegal;
    logic [15:0] stall_count;

    int checks = 0;
    int errors = 0;

    instr_decode_stage #(.FP_LAT(4), .IMM_SEXT(1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .instruction(instruction), .in_ready(in_ready), .out_valid(out_valid),
        .out_ready(out_ready), .branch(branch), .reg_write(reg_write),
        .mem_write(mem_write), .alu_src(alu_src), .jal(jal),
        .fp_reg_write(fp_reg_write), .fp_alu_src(fp_alu_src), .fp_reg_dst(fp_reg_dst),
        .jump(jump), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_ctrl(alu_ctrl),
        .fp_alu_ctrl(fp_alu_ctrl), .rs(rs), .rt(rt), .rd(rd), .imm(imm),
        .target(target), .illegal(illegal), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flush     = 1'b0;
        repeat (n) step();
    endtask

    function automatic logic [20:0] mk(input logic b, rw, mw, as, jl, fw, fas, fd, il,
                                       input logic [1:0] jp, rdst, m2r,
                                       input logic [2:0] alu, falu);
        return {b, rw, mw, as, jl, fw, fas, fd, il, jp, rdst, m2r, alu, falu};
    endfunction

    function automatic logic [20:0] observed();
        return {branch, reg_write, mem_write, alu_src, jal, fp_reg_write, fp_alu_src,
                fp_reg_dst, illegal, jump, reg_dst, mem_to_reg, alu_ctrl, fp_alu_ctrl};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        instruction = 32'h0;
        repeat (3) step();
        checks++;
        if ({out_valid, observed(), rs, rt, rd, imm, target, stall_count} !== '0) begin
            errors++;
            $display("FAIL reset_state: out_valid=%0b ctl=%h imm=%h stall=%0d required all zero",
                     out_valid, observed(), imm, stall_count);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %0b required 1", in_ready);
        end
        step();
    endtask

    task automatic test_add();
        instruction = 32'h014B4820;
        in_valid    = 1'b1;
        out_ready   = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_pre_valid: got %0b required 0", out_valid);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, reg_write, reg_dst, alu_ctrl, rs, rt, rd} !==
            {1'b1, 1'b1, 2'd1, 3'd0, 5'd10, 5'd11, 5'd9}) begin
            errors++;
            $display("FAIL add_bundle: valid=%0b rw=%0b rdst=%0d alu=%0d rs=%0d rt=%0d rd=%0d required 1 1 1 0 10 11 9",
                     out_valid, reg_write, reg_dst, alu_ctrl, rs, rt, rd);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_drain: out_valid=%0b required 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] words [16];
        logic [20:0] exp [16];
        logic [31:0] w;
        logic [31:0] exp_imm;
        words[0]  = 32'h8C000000; exp[0]  = mk(0,1,0,1,0,0,0,0,0, 2'd0,2'd0,2'd1, 3'd0,3'd0);
        words[1]  = 32'hAC000000; exp[1]  = mk(0,0,1,1,0,0,0,0,0, 2'd0,2'd0,2'd0, 3'd0,3'd0);
        words[2]  = 32'h08000123; exp[2]  = mk(0,0,0,0,0,0,0,0,0, 2'd2,2'd0,2'd0, 3'd0,3'd0);
        words[3]  = 32'h0C000040; exp[3]  = mk(0,1,0,0,1,0,0,0,0, 2'd2,2'd2,2'd2, 3'd0,3'd0);
        words[4]  = 32'h14A6FFFC; exp[4]  = mk(1,0,0,0,0,0,0,0,0, 2'd0,2'd0,2'd0, 3'd1,3'd0);
        words[5]  = 32'h2000FFFF; exp[5]  = mk(0,1,0,1,0,0,0,0,0, 2'd0,2'd0,2'd0, 3'd0,3'd0);
        words[6]  = 32'h00221822; exp[6]  = mk(0,1,0,0,0,0,0,0,0, 2'd0,2'd1,2'd0, 3'd1,3'd0);
        words[7]  = 32'h0000000E; exp[7]  = mk(0,1,0,1,0,0,0,0,0, 2'd0,2'd1,2'd0, 3'd2,3'd0);
        words[8]  = 32'h0000002A; exp[8]  = mk(0,1,0,0,0,0,0,0,0, 2'd0,2'd1,2'd0, 3'd3,3'd0);
        words[9]  = 32'h03E00008; exp[9]  = mk(0,0,0,0,0,0,0,0,0, 2'd1,2'd0,2'd0, 3'd0,3'd0);
        words[10] = 32'h0000003F; exp[10] = mk(0,0,0,0,0,0,0,0,1, 2'd0,2'd0,2'd0, 3'd0,3'd0);
        words[11] = 32'hFC000000; exp[11] = mk(0,0,0,0,0,0,0,0,1, 2'd0,2'd0,2'd0, 3'd0,3'd0);
        words[12] = 32'h44A63802; exp[12] = mk(0,0,0,0,0,1,0,1,0, 2'd0,2'd0,2'd0, 3'd0,3'd1);
        words[13] = 32'h49090000; exp[13] = mk(0,0,0,0,0,1,1,0,0, 2'd0,2'd0,2'd0, 3'd0,3'd1);
        words[14] = 32'h454B6004; exp[14] = mk(0,0,0,0,0,1,0,1,0, 2'd0,2'd0,2'd0, 3'd0,3'd3);
        words[15] = 32'h45AE7805; exp[15] = mk(0,0,0,0,0,0,0,0,1, 2'd0,2'd0,2'd0, 3'd0,3'd0);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int k = 0; k < 16; k++) begin
            instruction = words[k];
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL stream_ready[%0d]: got %0b required 1", k, in_ready);
            end
            step();
            w = words[k];
            exp_imm = (w[31:26] == 6'h03) ? 32'd8 : {{16{w[15]}}, w[15:0]};
            checks++;
            if ({out_valid, observed()} !== {1'b1, exp[k]}) begin
                errors++;
                $display("FAIL stream_ctl[%0d]: got valid=%0b ctl=%h required valid=1 ctl=%h",
                         k, out_valid, observed(), exp[k]);
            end
            checks++;
            if ({imm, rs, rt, rd, target} !== {exp_imm, w[25:21], w[20:16], w[15:11], w[25:0]}) begin
                errors++;
                $display("FAIL stream_fields[%0d]: imm=%h rs=%0d rt=%0d rd=%0d tgt=%h required imm=%h rs=%0d rt=%0d rd=%0d tgt=%h",
                         k, imm, rs, rt, rd, target, exp_imm, w[25:21], w[20:16], w[15:11], w[25:0]);
            end
        end
        idle(6);
    endtask

    task automatic test_hazard();
        out_ready   = 1'b1;
        in_valid    = 1'b1;
        instruction = 32'h44221800;
        step();
        instruction = 32'h44622000;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hazard_stall[%0d]: in_ready=%0b required 0", c, in_ready);
            end
            step();
        end
        #1;
        checks++;
        if ({in_ready, stall_count} !== {1'b1, 16'd4}) begin
            errors++;
            $display("FAIL hazard_release: in_ready=%0b stall=%0d required 1 4", in_ready, stall_count);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, fp_reg_write, rs, rd} !== {1'b1, 1'b1, 5'd3, 5'd4}) begin
            errors++;
            $display("FAIL hazard_accept: valid=%0b fpw=%0b rs=%0d rd=%0d required 1 1 3 4",
                     out_valid, fp_reg_write, rs, rd);
        end
        idle(6);
    endtask

    task automatic test_backpressure();
        out_ready   = 1'b1;
        in_valid    = 1'b1;
        instruction = 32'h014B4820;
        step();
        out_ready   = 1'b0;
        instruction = 32'hAC000000;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if ({in_ready, out_valid, reg_write, mem_write, rd} !== {1'b0, 1'b1, 1'b1, 1'b0, 5'd9}) begin
                errors++;
                $display("FAIL bp_hold[%0d]: ready=%0b valid=%0b rw=%0b mw=%0b rd=%0d required 0 1 1 0 9",
                         c, in_ready, out_valid, reg_write, mem_write, rd);
            end
            step();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: in_ready=%0b required 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, mem_write, reg_write} !== 3'b110) begin
            errors++;
            $display("FAIL bp_next: valid=%0b mw=%0b rw=%0b required 1 1 0", out_valid, mem_write, reg_write);
        end
        idle(6);
    endtask

    task automatic test_flush();
        out_ready   = 1'b0;
        in_valid    = 1'b1;
        instruction = 32'h44221800;
        step();
        flush       = 1'b1;
        instruction = 32'h44622000;
        #1;
        checks++;
        if ({out_valid, in_ready} !== 2'b10) begin
            errors++;
            $display("FAIL flush_pre: valid=%0b ready=%0b required 1 0", out_valid, in_ready);
        end
        step();
        flush     = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_kill: out_valid=%0b required 0", out_valid);
        end
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL flush_drain[%0d]: in_ready=%0b required 0", c, in_ready);
            end
            step();
        end
        #1;
        checks++;
        if ({in_ready, stall_count} !== {1'b1, 16'd8}) begin
            errors++;
            $display("FAIL flush_release: in_ready=%0b stall=%0d required 1 8", in_ready, stall_count);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, rd} !== {1'b1, 5'd4}) begin
            errors++;
            $display("FAIL flush_accept: valid=%0b rd=%0d required 1 4", out_valid, rd);
        end
        idle(6);
    endtask

    task automatic test_reset_mid();
        out_ready   = 1'b1;
        in_valid    = 1'b1;
        instruction = 32'h44221800;
        step();
        instruction = 32'h44622000;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, observed(), rs, rt, rd, imm, target, stall_count} !== '0) begin
            errors++;
            $display("FAIL reset_mid: valid=%0b ctl=%h rd=%0d stall=%0d required all zero",
                     out_valid, observed(), rd, stall_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_ready: in_ready=%0b required 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, fp_reg_write, rd} !== {1'b1, 1'b1, 5'd4}) begin
            errors++;
            $display("FAIL reset_mid_accept: valid=%0b fpw=%0b rd=%0d required 1 1 4",
                     out_valid, fp_reg_write, rd);
        end
        idle(2);
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_hazard();
        test_backpressure();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
